// File: rtl/bram_copy_engine_if.sv
// Control and memory-port bundle of the BRAM copy/fill engine.
// slave is the engine side; master is the requester/memory side.
interface bram_copy_engine_if #(
   parameter int address_width = 16,
   parameter int data_width    = 32,
   parameter int len_width     = 16
);
   logic                     start;
   logic                     abort;
   logic                     mode;
   logic [address_width-1:0] src_addr;
   logic [address_width-1:0] dst_addr;
   logic [len_width-1:0]     len_words;
   logic [data_width-1:0]    fill_value;
   logic                     busy;
   logic                     done;
   logic                     error;
   logic [address_width-1:0] mem_addr;
   logic [data_width/8-1:0]  mem_wr;
   logic [data_width-1:0]    mem_din;
   logic [data_width-1:0]    mem_dout;

   modport slave (
      input  start, abort, mode, src_addr, dst_addr,
      input  len_words, fill_value, mem_dout,
      output busy, done, error, mem_addr, mem_wr, mem_din
   );

   modport master (
      output start, abort, mode, src_addr, dst_addr,
      output len_words, fill_value, mem_dout,
      input  busy, done, error, mem_addr, mem_wr, mem_din
   );
endinterface

// File: rtl/bram_copy_engine.sv
// Word copy / fill engine for a synchronous-read block RAM.
// Copy word = RD, CAP, WR; fill word = WR only.
module bram_copy_engine #(
   parameter int address_width = 16,
   parameter int data_width    = 32,
   parameter int len_width     = 16
) (
   input logic               clk,
   input logic               reset,
   bram_copy_engine_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, RD, CAP, WR, DONE
   } state_t;

   localparam logic [address_width-1:0] step =
      address_width'(4);

   state_t                   state;
   state_t                   state_nx;
   logic [address_width-1:0] src_ptr;
   logic [address_width-1:0] dst_ptr;
   logic [len_width-1:0]     remaining;
   logic                     mode_q;
   logic [data_width-1:0]    fill_q;
   logic [data_width-1:0]    data_q;
   logic                     error_q;
   logic                     accept;
   logic                     misaligned;

   // abort beats start, so an aborted request latches nothing
   assign accept = (state == IDLE) && bus.start && !bus.abort;

   // source alignment only matters when the source is read
   assign misaligned = (bus.dst_addr[1:0] != 2'b00) ||
      (!bus.mode && (bus.src_addr[1:0] != 2'b00));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (misaligned)
                  state_nx = IDLE;
               else if (bus.len_words == '0)
                  state_nx = DONE;
               else if (bus.mode)
                  state_nx = WR;
               else
                  state_nx = RD;
            end
         end
         RD:  state_nx = bus.abort ? IDLE : CAP;
         CAP: state_nx = bus.abort ? IDLE : WR;
         WR: begin
            if (bus.abort)
               state_nx = IDLE;
            else if (remaining == len_width'(1))
               state_nx = DONE;
            else if (mode_q)
               state_nx = WR;
            else
               state_nx = RD;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.error    = error_q;
      bus.mem_addr = '0;
      bus.mem_wr   = '0;
      bus.mem_din  = '0;
      unique case (state)
         RD: begin
            bus.busy     = 1'b1;
            bus.mem_addr = src_ptr;
         end
         CAP: bus.busy = 1'b1;
         WR: begin
            bus.busy     = 1'b1;
            bus.mem_addr = dst_ptr;
            bus.mem_wr   = '1;
            bus.mem_din  = mode_q ? fill_q : data_q;
         end
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         mode_q    <= 1'b0;
         fill_q    <= '0;
         data_q    <= '0;
         error_q   <= 1'b0;
      end else begin
         error_q <= accept && misaligned;
         if (accept) begin
            src_ptr   <= bus.src_addr;
            dst_ptr   <= bus.dst_addr;
            remaining <= bus.len_words;
            mode_q    <= bus.mode;
            fill_q    <= bus.fill_value;
         end
         if (state == CAP)
            data_q <= bus.mem_dout;
         if (state == WR) begin
            remaining <= remaining - len_width'(1);
            src_ptr   <= src_ptr + step;
            dst_ptr   <= dst_ptr + step;
         end
      end
   end

endmodule

// File: tb/tb_bram_copy_engine.sv
// Randomized self-checking bench for bram_copy_engine.
// Expected writes and timing come from a sequential word model.
module tb_bram_copy_engine;

   localparam int AW    = 16;
   localparam int LW    = 16;
   localparam int WORDS = 1 << (AW - 2);

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic [3:0]    wr;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_req = 1'b0;
   logic [31:0] rdata;
   logic [31:0] mem [WORDS];
   logic [31:0] ref_mem [WORDS];
   wr_t         wlog [$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   bram_copy_engine_if #(
      .address_width(AW), .data_width(32), .len_width(LW)
   ) bus ();

   bram_copy_engine #(
      .address_width(AW), .data_width(32), .len_width(LW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   assign bus.mem_dout = rdata;

   // synchronous-read RAM; logs every write it sees
   always @(posedge clk) begin
      if (load_req) begin
         for (int i = 0; i < WORDS; i++)
            mem[i] <= ref_mem[i];
      end else if (bus.mem_wr != 4'h0) begin
         mem[bus.mem_addr[AW-1:2]] <= bus.mem_din;
         wlog.push_back({bus.mem_addr, bus.mem_din, bus.mem_wr});
      end else begin
         rdata <= mem[bus.mem_addr[AW-1:2]];
      end
   end

   task automatic load_mem;
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic randomize_ref;
      for (int i = 0; i < WORDS; i++)
         ref_mem[i] = $urandom;
   endtask

   task automatic scramble_inputs;
      bus.mode       = 1'($urandom_range(0, 1));
      bus.src_addr   = AW'($urandom);
      bus.dst_addr   = AW'($urandom);
      bus.len_words  = LW'($urandom);
      bus.fill_value = $urandom;
   endtask

   // abort_cyc: -1 none, 0 together with start, k>0 at cycle k
   task automatic do_op(input bit m, input logic [AW-1:0] s,
                        input logic [AW-1:0] d, input int n,
                        input logic [31:0] f, input int abort_cyc,
                        input bit hold, input string tag);
      bit            mis;
      int            exp_done = -1;
      int            exp_err = 0;
      int            active = 0;
      int            nwr = 0;
      int            limit;
      int            done_first = -1;
      int            done_cnt = 0;
      int            err_first = -1;
      int            err_cnt = 0;
      int            busy_bad = 0;
      int            wr_bad = 0;
      int            mem_bad = 0;
      logic [AW-1:0] a;
      logic [AW-1:0] ra;
      logic [31:0]   v;
      wr_t           exp_wr [$];

      mis = (d[1:0] != 2'b00) || (!m && (s[1:0] != 2'b00));
      if (abort_cyc == 0) begin
         exp_err = 0;
      end else if (mis) begin
         exp_err = 1;
      end else if (n == 0) begin
         exp_done = 1;
      end else begin
         active = m ? n : 3 * n;
         if (abort_cyc > 0 && abort_cyc <= active) begin
            active = abort_cyc;
            nwr = m ? abort_cyc : abort_cyc / 3;
         end else begin
            nwr = n;
            exp_done = active + 1;
         end
      end
      for (int i = 0; i < nwr; i++) begin
         a  = d + AW'(4 * i);
         ra = s + AW'(4 * i);
         v  = m ? f : ref_mem[ra[AW-1:2]];
         ref_mem[a[AW-1:2]] = v;
         exp_wr.push_back({a, v, 4'hF});
      end

      @(negedge clk);
      wlog.delete();
      bus.mode       = m;
      bus.src_addr   = s;
      bus.dst_addr   = d;
      bus.len_words  = LW'(n);
      bus.fill_value = f;
      bus.start      = 1'b1;
      bus.abort      = (abort_cyc == 0);
      limit = ((exp_done > active) ? exp_done : active) + 4;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_first < 0) done_first = k;
         end
         if (bus.error === 1'b1) begin
            err_cnt++;
            if (err_first < 0) err_first = k;
         end
         if (bus.busy !== ((k <= active) ? 1'b1 : 1'b0))
            busy_bad++;
         scramble_inputs();
         bus.start = hold && (k <= exp_done);
         bus.abort = (k == abort_cyc);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;

      checks++;
      if (done_first != exp_done ||
          done_cnt != ((exp_done > 0) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s done: cycle %0d count %0d, expected cycle %0d",
                  tag, done_first, done_cnt, exp_done);
      end
      checks++;
      if (err_cnt != exp_err ||
          (exp_err == 1 && err_first != 1)) begin
         errors++;
         $display("FAIL %s error: count %0d at %0d, expected count %0d",
                  tag, err_cnt, err_first, exp_err);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL %s busy: %0d bad cycles, expected %0d busy cycles",
                  tag, busy_bad, active);
      end
      if (wlog.size() != exp_wr.size()) begin
         wr_bad = 1;
      end else begin
         foreach (exp_wr[i])
            if (wlog[i] !== exp_wr[i]) wr_bad++;
      end
      checks++;
      if (wr_bad != 0) begin
         errors++;
         $display("FAIL %s writes: got %0d (%0d wrong), expected %0d",
                  tag, wlog.size(), wr_bad, exp_wr.size());
      end
      for (int i = 0; i < WORDS; i++)
         if (mem[i] !== ref_mem[i]) mem_bad++;
      checks++;
      if (mem_bad != 0) begin
         errors++;
         $display("FAIL %s memory: %0d words differ, expected 0",
                  tag, mem_bad);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2;
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset busy: got %b expected 0", bus.busy);
      end
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset done: got %b expected 0", bus.done);
      end
      checks++;
      if (bus.error !== 1'b0) begin
         errors++;
         $display("FAIL reset error: got %b expected 0", bus.error);
      end
      checks++;
      if (bus.mem_wr !== 4'h0) begin
         errors++;
         $display("FAIL reset mem_wr: got %h expected 0", bus.mem_wr);
      end
      checks++;
      if (bus.mem_addr !== '0 || bus.mem_din !== '0) begin
         errors++;
         $display("FAIL reset mem_bus: addr %h din %h expected 0",
                  bus.mem_addr, bus.mem_din);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_copy_basic;
      randomize_ref();
      for (int i = 0; i < 4; i++)
         ref_mem[i] = 32'h1111_1111 * (i + 1);
      load_mem();
      do_op(1'b0, 16'h0000, 16'h0100, 4, 32'h0, -1, 1'b0, "copy4");
   endtask

   task automatic test_fill_basic;
      do_op(1'b1, 16'h0000, 16'h0040, 3, 32'hDEAD_BEEF, -1, 1'b0,
            "fill3");
   endtask

   task automatic test_error;
      do_op(1'b0, 16'h0000, 16'h0102, 4, 32'h0, -1, 1'b0, "dst_mis");
      do_op(1'b1, 16'h0000, 16'h0103, 2, 32'h5, -1, 1'b0, "fill_mis");
      do_op(1'b0, 16'h0201, 16'h0300, 2, 32'h0, -1, 1'b0, "src_mis");
      do_op(1'b1, 16'h0201, 16'h0300, 2, 32'h7, -1, 1'b0,
            "fill_src_ok");
   endtask

   task automatic test_len_zero;
      do_op(1'b0, 16'h0000, 16'h0100, 0, 32'h0, -1, 1'b0, "copy_len0");
      do_op(1'b1, 16'h0000, 16'h0100, 0, 32'h9, -1, 1'b0, "fill_len0");
   endtask

   task automatic test_abort;
      do_op(1'b0, 16'h0400, 16'h0500, 8, 32'h0, 8, 1'b0, "abort_cap");
      do_op(1'b0, 16'h0400, 16'h0600, 5, 32'h0, 6, 1'b0, "abort_wr");
      do_op(1'b1, 16'h0000, 16'h0700, 6, 32'hA5A5_0001, 2, 1'b0,
            "abort_fill");
      do_op(1'b0, 16'h0400, 16'h0800, 3, 32'h0, 0, 1'b0,
            "abort_start");
   endtask

   task automatic test_wrap;
      do_op(1'b1, 16'h0000, 16'hFFFC, 2, 32'hCAFE_F00D, -1, 1'b0,
            "fill_wrap");
      do_op(1'b0, 16'hFFF8, 16'h0900, 3, 32'h0, -1, 1'b0, "copy_wrap");
   endtask

   task automatic test_overlap;
      do_op(1'b0, 16'h0A00, 16'h0A04, 5, 32'h0, -1, 1'b0, "ovl_up");
      do_op(1'b0, 16'h0B08, 16'h0B00, 5, 32'h0, -1, 1'b0, "ovl_down");
   endtask

   task automatic test_back_to_back;
      do_op(1'b1, 16'h0000, 16'h0C00, 3, 32'h1234_5678, -1, 1'b1,
            "hold_fill");
      do_op(1'b0, 16'h0C00, 16'h0D00, 2, 32'h0, -1, 1'b1, "hold_copy");
      do_op(1'b1, 16'h0000, 16'h0E00, 0, 32'h1, -1, 1'b1, "hold_len0");
   endtask

   task automatic test_reset_mid_write;
      logic [31:0] f;
      f = $urandom;
      @(negedge clk);
      wlog.delete();
      bus.mode       = 1'b1;
      bus.dst_addr   = 16'h0F00;
      bus.len_words  = LW'(4);
      bus.fill_value = f;
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.mem_wr !== 4'h0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: mem_wr %h busy %b expected 0 0",
                  bus.mem_wr, bus.busy);
      end
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (wlog.size() != 1) begin
         errors++;
         $display("FAIL reset_writes: got %0d writes expected 1",
                  wlog.size());
      end else if (wlog[0] !== {16'h0F00, f, 4'hF}) begin
         errors++;
         $display("FAIL reset_writes: got %h expected %h",
                  wlog[0], {16'h0F00, f, 4'hF});
      end
      ref_mem[16'h0F00 >> 2] = f;
      do_op(1'b0, 16'h0F00, 16'h0F40, 3, 32'h0, -1, 1'b0,
            "after_reset");
   endtask

   task automatic test_random;
      bit            m;
      bit            mis;
      bit            hold;
      int            n;
      int            ac;
      logic [AW-1:0] s;
      logic [AW-1:0] d;
      for (int t = 0; t < 24; t++) begin
         m = 1'($urandom_range(0, 1));
         n = $urandom_range(0, 10);
         s = AW'($urandom) & ~AW'(3);
         d = AW'($urandom) & ~AW'(3);
         if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
         mis = (d[1:0] != 2'b00) || (!m && (s[1:0] != 2'b00));
         ac = -1;
         if (n > 0 && $urandom_range(0, 3) == 0)
            ac = $urandom_range(1, m ? n : 3 * n);
         else if ($urandom_range(0, 15) == 0)
            ac = 0;
         hold = !mis && ac < 0 && ($urandom_range(0, 3) == 0);
         do_op(m, s, d, n, $urandom, ac, hold, "random");
      end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.mode       = 1'b0;
      bus.src_addr   = '0;
      bus.dst_addr   = '0;
      bus.len_words  = '0;
      bus.fill_value = '0;
      test_reset();
      test_copy_basic();
      test_fill_basic();
      test_error();
      test_len_zero();
      test_abort();
      test_wrap();
      test_overlap();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_copy_engine.md
BRAM_COPY_ENGINE -- requirements
Module: bram_copy_engine

Interface
REQ-001 SHALL have parameter address_width, default 16: byte-address width of the memory bus.
REQ-002 SHALL have parameter data_width, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter len_width, default 16: width of the word-count input.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request, sampled in IDLE only.
REQ-007 abort  input  1  cancels the operation in progress.
REQ-008 mode  input  1  0 = copy (read src, write dst); 1 = fill (write fill_value to dst).
REQ-009 src_addr  input  address_width  source byte address.
REQ-010 dst_addr  input  address_width  destination byte address.
REQ-011 len_words  input  len_width  number of 32-bit words to move.
REQ-012 fill_value  input  32  word written in fill mode.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  one-cycle pulse on normal completion.
REQ-015 error  output  1  one-cycle pulse on rejected start.
REQ-016 mem_addr  output  address_width  byte address to memory.
REQ-017 mem_wr  output  4  byte write enables to memory.
REQ-018 mem_din  output  32  write data to memory.
REQ-019 mem_dout  input  32  read data from memory, valid the cycle after mem_addr is presented with mem_wr=0.

Function
REQ-020 SHALL implement states IDLE, RD, CAP, WR, DONE; all outputs registered or decoded from registered state.
REQ-021 In IDLE with start=1 and abort=0, SHALL latch src_addr, dst_addr, len_words, mode, fill_value at that edge; later input changes are ignored.
REQ-022 If latched src_addr[1:0]!=0 (copy mode) or dst_addr[1:0]!=0, SHALL pulse error for one cycle, stay IDLE, issue no memory write.
REQ-023 If len_words=0, SHALL go to DONE with no memory access.
REQ-024 Copy, word i: RD drives mem_addr=src+4i, mem_wr=0; CAP captures mem_dout into the data register; WR drives mem_addr=dst+4i, mem_wr=4'hF, mem_din=data register.
REQ-025 Fill, word i: WR only; mem_addr=dst+4i, mem_wr=4'hF, mem_din=fill_value.
REQ-026 Copy SHALL take 3 cycles per word; fill 1 cycle per word; no idle cycles between words.
REQ-027 After the last WR, SHALL enter DONE for exactly one cycle (done=1, busy=0), then return to IDLE.
REQ-028 busy SHALL be 1 in RD, CAP, WR; 0 in IDLE and DONE.
REQ-029 mem_wr SHALL be 4'h0 in every state except WR.
REQ-030 Address increments SHALL wrap modulo 2^address_width.
REQ-031 start while busy or in DONE SHALL be ignored.
REQ-032 abort=1 in RD, CAP, or WR SHALL force IDLE at the next edge; a WR cycle in progress completes its write; no further access; done not pulsed.
REQ-033 abort and start both high in IDLE: abort wins and nothing is latched.
REQ-034 Overlapping src/dst ranges SHALL be copied in ascending address order with no hazard checking.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, busy=0, done=0, error=0, mem_wr=0, mem_addr=0, mem_din=0, and clear all latched registers, independent of clk.
REQ-036 reset asserted mid-operation SHALL abandon the transfer; no memory write occurs after reset asserts.

Verification
REQ-037 Copy, src=0x000, dst=0x100, len=4, memory preloaded with 0x11111111..0x44444444 -> dst words match; done pulses exactly 13 cycles after the start edge; 4 WR cycles observed.
REQ-038 Fill, dst=0x040, len=3, fill_value=0xDEADBEEF -> 3 consecutive WR cycles at 0x040/0x044/0x048; done on the 4th cycle.
REQ-039 start with dst=0x102 -> error pulse, busy stays 0, mem_wr never nonzero; start with len=0 -> done next cycle, no access.
REQ-040 Copy len=8, abort asserted during the 3rd word's CAP -> exactly 2 writes; IDLE next cycle; done never asserted.
REQ-041 Fill len=2, dst=2^address_width-4 -> writes at top word then address 0x0.
REQ-042 Asynchronous reset pulse between clock edges during WR -> mem_wr and busy drop immediately; subsequent start works normally.
